// File: rtl/hdmi_phy_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_phy_ctrl_if
// Description : Lane and status bundle between the TMDS encoders, the PHY
//               startup sequencer and the PHY wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_phy_ctrl_if;
    logic [9:0] I_tmds_ch0;
    logic [9:0] I_tmds_ch1;
    logic [9:0] I_tmds_ch2;
    logic [9:0] O_tmds_channel_0;
    logic [9:0] O_tmds_channel_1;
    logic [9:0] O_tmds_channel_2;
    logic [9:0] O_tmds_channel_clk;
    logic       O_phy_rst;
    logic       O_ready;
    logic [2:0] O_state;

    modport master (
        output I_tmds_ch0, I_tmds_ch1, I_tmds_ch2,
        input  O_tmds_channel_0, O_tmds_channel_1, O_tmds_channel_2,
        input  O_tmds_channel_clk, O_phy_rst, O_ready, O_state
    );

    modport slave (
        input  I_tmds_ch0, I_tmds_ch1, I_tmds_ch2,
        output O_tmds_channel_0, O_tmds_channel_1, O_tmds_channel_2,
        output O_tmds_channel_clk, O_phy_rst, O_ready, O_state
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_phy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_phy_ctrl
// Description : TMDS PHY startup/recovery sequencer: PLL-lock filter, serializer
//               reset, control-token preamble, then encoder passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_phy_ctrl #(
    parameter int LOCK_FILTER     = 1024,
    parameter int PHY_RST_CYCLES  = 16,
    parameter int PREAMBLE_CYCLES = 64
) (
    input  wire logic           I_pixel_clk,
    input  wire logic           I_rst,
    input  wire logic           I_pll_lock,
    input  wire logic           I_restart,
    hdmi_phy_ctrl_if.slave      phy_bus
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_PHY_RST   = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

    localparam logic [9:0]  c_ctrl_token   = 10'b1101010100;
    localparam logic [9:0]  c_clk_word     = 10'b0000011111;
    localparam logic [15:0] c_lock_last    = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] c_rst_last     = 16'(PHY_RST_CYCLES - 1);
    localparam logic [15:0] c_preamble_last = 16'(PREAMBLE_CYCLES - 1);

    logic        r_lock_meta;
    logic        r_lock_s;
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_reenter;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_phy_rst;
    logic        r_ready;
    logic [9:0]  r_ch0;
    logic [9:0]  r_ch1;
    logic [9:0]  r_ch2;

    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= 16'd0;
        end else begin
            r_lock_meta <= I_pll_lock;
            r_lock_s    <= r_lock_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Lock loss is tested first in every active state so it outranks restart.
    always_comb begin
        w_state_nxt = r_state;
        w_reenter   = 1'b0;
        w_cnt_nxt   = r_cnt + 16'd1;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (r_lock_s && (r_cnt == c_lock_last)) begin
                    w_state_nxt = ST_PHY_RST;
                end
            end
            ST_PHY_RST: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (I_restart) begin
                    w_reenter = 1'b1;
                end else if (r_cnt == c_rst_last) begin
                    w_state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (I_restart) begin
                    w_state_nxt = ST_PHY_RST;
                end else if (r_cnt == c_preamble_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (I_restart) begin
                    w_state_nxt = ST_PHY_RST;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase

        if ((w_state_nxt != r_state) || w_reenter) begin
            w_cnt_nxt = 16'd0;
        end else if ((r_state == ST_WAIT_LOCK) && !r_lock_s) begin
            w_cnt_nxt = 16'd0;
        end else if (r_state == ST_RUN) begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            r_phy_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_ch0     <= c_ctrl_token;
            r_ch1     <= c_ctrl_token;
            r_ch2     <= c_ctrl_token;
        end else begin
            r_phy_rst <= (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_PHY_RST);
            r_ready   <= (w_state_nxt == ST_RUN);
            r_ch0     <= (w_state_nxt == ST_RUN) ? phy_bus.I_tmds_ch0 : c_ctrl_token;
            r_ch1     <= (w_state_nxt == ST_RUN) ? phy_bus.I_tmds_ch1 : c_ctrl_token;
            r_ch2     <= (w_state_nxt == ST_RUN) ? phy_bus.I_tmds_ch2 : c_ctrl_token;
        end
    end

    assign phy_bus.O_phy_rst          = r_phy_rst;
    assign phy_bus.O_ready            = r_ready;
    assign phy_bus.O_state            = r_state;
    assign phy_bus.O_tmds_channel_0   = r_ch0;
    assign phy_bus.O_tmds_channel_1   = r_ch1;
    assign phy_bus.O_tmds_channel_2   = r_ch2;
    assign phy_bus.O_tmds_channel_clk = c_clk_word;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_phy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_phy_ctrl
// Description : Self-checking bench for hdmi_phy_ctrl against an elapsed-time
//               reference model, directed timing checks plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_phy_ctrl;

    localparam int         c_lf    = 4;
    localparam int         c_pr    = 3;
    localparam int         c_pa    = 5;
    localparam logic [9:0] c_token = 10'h354;
    localparam logic [9:0] c_clkw  = 10'h01F;

    logic clk;
    logic rst;
    logic pll;
    logic restart;

    hdmi_phy_ctrl_if bus ();

    hdmi_phy_ctrl #(
        .LOCK_FILTER     (c_lf),
        .PHY_RST_CYCLES  (c_pr),
        .PREAMBLE_CYCLES (c_pa)
    ) u_dut (
        .I_pixel_clk (clk),
        .I_rst       (rst),
        .I_pll_lock  (pll),
        .I_restart   (restart),
        .phy_bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    // Model: m_seq is -1 while waiting for lock, else edges since PHY reset began.
    bit         m_meta, m_ls;
    int         m_seq, m_run;
    int         exp_state;
    logic [9:0] exp_d0, exp_d1, exp_d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_meta = 0; m_ls = 0; m_seq = -1; m_run = 0;
        exp_state = 0;
        exp_d0 = c_token; exp_d1 = c_token; exp_d2 = c_token;
    endtask

    task automatic model_edge();
        bit ls;
        ls = m_ls;
        m_ls = m_meta;
        m_meta = pll;
        if (m_seq < 0) begin
            if (ls) begin
                m_run++;
                if (m_run == c_lf) m_seq = 0;
            end else begin
                m_run = 0;
            end
        end else if (!ls) begin
            m_seq = -1;
            m_run = 0;
        end else if (restart) begin
            m_seq = 0;
        end else if (m_seq < c_pr + c_pa) begin
            m_seq++;
        end
        if (m_seq < 0)                exp_state = 0;
        else if (m_seq < c_pr)        exp_state = 1;
        else if (m_seq < c_pr + c_pa) exp_state = 2;
        else                          exp_state = 3;
        if (exp_state == 3) begin
            exp_d0 = bus.I_tmds_ch0; exp_d1 = bus.I_tmds_ch1; exp_d2 = bus.I_tmds_ch2;
        end else begin
            exp_d0 = c_token; exp_d1 = c_token; exp_d2 = c_token;
        end
    endtask

    task automatic compare_all();
        check("state",   32'(bus.O_state), 32'(exp_state));
        check("phy_rst", 32'(bus.O_phy_rst), 32'(exp_state < 2));
        check("ready",   32'(bus.O_ready), 32'(exp_state == 3));
        check("ch0",     32'(bus.O_tmds_channel_0), 32'(exp_d0));
        check("ch1",     32'(bus.O_tmds_channel_1), 32'(exp_d1));
        check("ch2",     32'(bus.O_tmds_channel_2), 32'(exp_d2));
        check("clk_ln",  32'(bus.O_tmds_channel_clk), 32'(c_clkw));
    endtask

    task automatic step();
        @(posedge clk);
        edge_cnt++;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"},   32'(bus.O_state), 32'd0);
        check({pfx, "_phy_rst"}, 32'(bus.O_phy_rst), 32'd1);
        check({pfx, "_ready"},   32'(bus.O_ready), 32'd0);
        check({pfx, "_ch0"},     32'(bus.O_tmds_channel_0), 32'(c_token));
        check({pfx, "_ch2"},     32'(bus.O_tmds_channel_2), 32'(c_token));
        check({pfx, "_clk"},     32'(bus.O_tmds_channel_clk), 32'(c_clkw));
    endtask

    // Called just after a negedge; reset pulse stays clear of the next posedge.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1 check_reset_vals("arst");
        model_reset();
        #1 rst = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!bus.O_ready && n < 40) begin
            step();
            n++;
        end
        check({tag, "_reach_run"}, 32'(bus.O_ready), 32'd1);
    endtask

    task automatic edges_to_phy_rst(input string tag, input int exp_n);
        int n;
        n = 0;
        while (bus.O_state != 3'd1 && n < 40) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        int t_rst, t_fall, t_rdy, n, drop_left;
        rst = 1'b1; pll = 1'b0; restart = 1'b0;
        bus.I_tmds_ch0 = '0; bus.I_tmds_ch1 = '0; bus.I_tmds_ch2 = '0;
        model_reset();
        #2 check_reset_vals("rst");
        #20 rst = 1'b0;

        // Lock-up timeline: lock raised after edge 10
        repeat (10) step();
        pll = 1'b1;
        t_rst = -1; t_fall = -1; t_rdy = -1;
        repeat (20) begin
            step();
            if (bus.O_state == 3'd1 && t_rst < 0) t_rst = edge_cnt;
            if (!bus.O_phy_rst && t_fall < 0)      t_fall = edge_cnt;
            if (bus.O_ready && t_rdy < 0)          t_rdy = edge_cnt;
        end
        check("lockup_phy_rst_edge", 32'(t_rst), 32'd16);
        check("lockup_rst_fall_edge", 32'(t_fall), 32'd19);
        check("lockup_ready_edge", 32'(t_rdy), 32'd24);

        // Passthrough
        bus.I_tmds_ch0 = 10'h2AB; bus.I_tmds_ch1 = 10'h155; bus.I_tmds_ch2 = 10'h3FF;
        step();
        check("pass_ch0", 32'(bus.O_tmds_channel_0), 32'h2AB);
        check("pass_ch1", 32'(bus.O_tmds_channel_1), 32'h155);
        check("pass_ch2", 32'(bus.O_tmds_channel_2), 32'h3FF);

        // Lock loss in RUN: three edges to WAIT_LOCK
        pll = 1'b0;
        step(); step();
        check("loss_still_run", 32'(bus.O_ready), 32'd1);
        step();
        check("loss_state", 32'(bus.O_state), 32'd0);
        pll = 1'b1;
        wait_run("relock");

        // Restart in RUN: PHY reset dwell
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_state", 32'(bus.O_state), 32'd1);
        n = 1;
        repeat (10) begin
            step();
            if (bus.O_phy_rst) n++;
            else break;
        end
        check("restart_dwell", 32'(n), 32'(c_pr));
        wait_run("after_restart");

        // Restart with lock already low in the synchronizer goes to WAIT_LOCK
        pll = 1'b0;
        step(); step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_lock_low", 32'(bus.O_state), 32'd0);

        // Async reset mid-PREAMBLE, lock held high
        pll = 1'b1;
        n = 0;
        while (bus.O_state != 3'd2 && n < 40) begin
            step();
            n++;
        end
        check("reach_preamble", 32'(bus.O_state), 32'd2);
        step();
        async_reset();
        edges_to_phy_rst("arst_relock_edges", c_lf + 2);

        // Lock glitch in WAIT_LOCK restarts the filter
        pll = 1'b0;
        repeat (4) step();
        pll = 1'b1;
        repeat (3) step();
        pll = 1'b0;
        step();
        pll = 1'b1;
        edges_to_phy_rst("glitch_edges", c_lf + 2);

        // Random phase
        drop_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (drop_left > 0) begin
                pll = 1'b0;
                drop_left--;
            end else if ($urandom_range(0, 79) == 0) begin
                pll = 1'b0;
                drop_left = $urandom_range(0, 5);
            end else begin
                pll = 1'b1;
            end
            restart = ($urandom_range(0, 29) == 0);
            bus.I_tmds_ch0 = 10'($urandom_range(0, 1023));
            bus.I_tmds_ch1 = 10'($urandom_range(0, 1023));
            bus.I_tmds_ch2 = 10'($urandom_range(0, 1023));
            step();
            if ($urandom_range(0, 599) == 0) async_reset();
        end
        restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
